// File: rtl/ram_arb_pkg.sv
// Shared types and sizing helpers for the two-port
// RAM arbiter.
package ram_arb_pkg;

  localparam int ADDR_W_DEF    = 6;
  localparam int DATA_W_DEF    = 8;
  localparam int BURST_MAX_DEF = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_e;

  function automatic int cnt_w(input int burst_max);
    return $clog2(burst_max + 1);
  endfunction

endpackage

// File: rtl/ram_arb_grant.sv
// Round-robin grant with bounded bursts, plus the
// next-state and beat-count update.
module ram_arb_grant
  import ram_arb_pkg::*;
#(
  parameter int  BURST_MAX = BURST_MAX_DEF,
  localparam int CNT_W     = cnt_w(BURST_MAX)
) (
  input  state_e           state_i,
  input  logic             last_owner_i,
  input  logic [CNT_W-1:0] beat_cnt_i,
  input  logic [1:0]       valid_i,
  output logic [1:0]       grant_o,
  output state_e           state_d_o,
  output logic             last_owner_d_o,
  output logic [CNT_W-1:0] beat_cnt_d_o
);

  localparam logic [CNT_W-1:0] BMAX = CNT_W'(BURST_MAX);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  logic owner;
  logic own_v;
  logic oth_v;
  logic keep;
  logic sw;
  logic rst_cnt;
  logic gnt_id;

  always_comb begin
    unique case (state_i)
      OWN0:    owner = 1'b0;
      OWN1:    owner = 1'b1;
      default: owner = last_owner_i;
    endcase
  end

  assign own_v = valid_i[owner];
  assign oth_v = valid_i[~owner];

  // From IDLE the owner gets no burst priority, so the
  // other side wins a tie.
  assign keep    = (state_i != IDLE) && own_v
                   && (beat_cnt_i < BMAX);
  assign sw      = !keep && oth_v;
  assign rst_cnt = !keep && !oth_v && own_v;

  always_comb begin
    grant_o        = '0;
    state_d_o      = IDLE;
    last_owner_d_o = last_owner_i;
    beat_cnt_d_o   = '0;
    gnt_id         = owner;
    unique case (1'b1)
      keep: begin
        gnt_id       = owner;
        beat_cnt_d_o = beat_cnt_i + ONE;
      end
      sw: begin
        gnt_id       = ~owner;
        beat_cnt_d_o = ONE;
      end
      rst_cnt: begin
        gnt_id       = owner;
        beat_cnt_d_o = ONE;
      end
      default: ;
    endcase
    if (keep || sw || rst_cnt) begin
      grant_o[gnt_id] = 1'b1;
      state_d_o       = gnt_id ? OWN1 : OWN0;
      last_owner_d_o  = gnt_id;
    end
  end

endmodule

// File: rtl/ram64x8_port_arbiter.sv
// Two requesters sharing one single-port RAM, with
// tagged read responses returned to their owner.
module ram64x8_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int BURST_MAX = BURST_MAX_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req0_valid,
  input  logic              req0_write,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic              req1_write,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              req1_ready,
  output logic              rsp0_valid,
  output logic [DATA_W-1:0] rsp0_rdata,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp1_rdata,
  output logic              ram_enable,
  output logic              ram_read,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_data_in,
  input  logic [DATA_W-1:0] ram_data_out
);

  localparam int CNT_W = cnt_w(BURST_MAX);

  state_e             state_q, state_d;
  logic               last_owner_q, last_owner_d;
  logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_d;
  logic [1:0]         rd_pend_q, rd_pend_d;
  logic [1:0]         rsp_valid_q;
  logic [DATA_W-1:0]  rsp0_rdata_q, rsp0_rdata_d;
  logic [DATA_W-1:0]  rsp1_rdata_q, rsp1_rdata_d;
  logic [1:0]         grant_raw;
  logic [1:0]         grant;

  ram_arb_grant #(
    .BURST_MAX (BURST_MAX)
  ) u_grant (
    .state_i        (state_q),
    .last_owner_i   (last_owner_q),
    .beat_cnt_i     (beat_cnt_q),
    .valid_i        ({req1_valid, req0_valid}),
    .grant_o        (grant_raw),
    .state_d_o      (state_d),
    .last_owner_d_o (last_owner_d),
    .beat_cnt_d_o   (beat_cnt_d)
  );

  // Ready and RAM strobes must drop the moment reset
  // asserts, even with commands held valid.
  assign grant = reset_n ? grant_raw : 2'b00;

  assign req0_ready = grant[0];
  assign req1_ready = grant[1];

  always_comb begin
    ram_enable  = 1'b0;
    ram_read    = 1'b0;
    ram_address = '0;
    ram_data_in = '0;
    unique case (1'b1)
      grant[0]: begin
        ram_enable  = 1'b1;
        ram_read    = ~req0_write;
        ram_address = req0_addr;
        ram_data_in = req0_wdata;
      end
      grant[1]: begin
        ram_enable  = 1'b1;
        ram_read    = ~req1_write;
        ram_address = req1_addr;
        ram_data_in = req1_wdata;
      end
      default: ;
    endcase
  end

  assign rd_pend_d = {grant[1] & ~req1_write,
                      grant[0] & ~req0_write};

  assign rsp0_rdata_d = rd_pend_q[0] ? ram_data_out
                                     : rsp0_rdata_q;
  assign rsp1_rdata_d = rd_pend_q[1] ? ram_data_out
                                     : rsp1_rdata_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      last_owner_q <= 1'b1;
      beat_cnt_q   <= '0;
      rd_pend_q    <= '0;
      rsp_valid_q  <= '0;
      rsp0_rdata_q <= '0;
      rsp1_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
      beat_cnt_q   <= beat_cnt_d;
      rd_pend_q    <= rd_pend_d;
      rsp_valid_q  <= rd_pend_q;
      rsp0_rdata_q <= rsp0_rdata_d;
      rsp1_rdata_q <= rsp1_rdata_d;
    end
  end

  assign rsp0_valid = rsp_valid_q[0];
  assign rsp1_valid = rsp_valid_q[1];
  assign rsp0_rdata = rsp0_rdata_q;
  assign rsp1_rdata = rsp1_rdata_q;

endmodule

// File: tb/tb_ram64x8_port_arbiter.sv
// Directed bench for ram64x8_port_arbiter with a
// behavioural 64x8 single-port RAM.
module tb_ram64x8_port_arbiter;

  logic       clk;
  logic       reset_n;
  logic       req0_valid, req0_write;
  logic [5:0] req0_addr;
  logic [7:0] req0_wdata;
  logic       req0_ready;
  logic       req1_valid, req1_write;
  logic [5:0] req1_addr;
  logic [7:0] req1_wdata;
  logic       req1_ready;
  logic       rsp0_valid, rsp1_valid;
  logic [7:0] rsp0_rdata, rsp1_rdata;
  logic       ram_enable, ram_read;
  logic [5:0] ram_address;
  logic [7:0] ram_data_in, ram_data_out;

  logic [7:0] mem [64];

  int n_cmp;
  int n_err;

  ram64x8_port_arbiter dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .req0_valid   (req0_valid),
    .req0_write   (req0_write),
    .req0_addr    (req0_addr),
    .req0_wdata   (req0_wdata),
    .req0_ready   (req0_ready),
    .req1_valid   (req1_valid),
    .req1_write   (req1_write),
    .req1_addr    (req1_addr),
    .req1_wdata   (req1_wdata),
    .req1_ready   (req1_ready),
    .rsp0_valid   (rsp0_valid),
    .rsp0_rdata   (rsp0_rdata),
    .rsp1_valid   (rsp1_valid),
    .rsp1_rdata   (rsp1_rdata),
    .ram_enable   (ram_enable),
    .ram_read     (ram_read),
    .ram_address  (ram_address),
    .ram_data_in  (ram_data_in),
    .ram_data_out (ram_data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_enable) begin
      if (ram_read) ram_data_out <= mem[ram_address];
      else mem[ram_address] <= ram_data_in;
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set0(input logic v, input logic w,
                      input logic [5:0] a,
                      input logic [7:0] d);
    req0_valid = v;
    req0_write = w;
    req0_addr  = a;
    req0_wdata = d;
  endtask

  task automatic set1(input logic v, input logic w,
                      input logic [5:0] a,
                      input logic [7:0] d);
    req1_valid = v;
    req1_write = w;
    req1_addr  = a;
    req1_wdata = d;
  endtask

  int gexp [9] = '{0, 0, 0, 0, 1, 1, 1, 1, 0};

  initial begin
    n_cmp = 0;
    n_err = 0;
    ram_data_out = '0;
    for (int i = 0; i < 64; i++) mem[i] = 8'h00;
    reset_n = 1'b0;
    set0(1'b1, 1'b0, 6'h00, 8'h00);
    set1(1'b1, 1'b0, 6'h01, 8'h00);

    // reset state
    #2;
    chk("rst_ready0", req0_ready, 0);
    chk("rst_ready1", req1_ready, 0);
    chk("rst_ram_en", ram_enable, 0);
    chk("rst_ram_addr", ram_address, 0);
    chk("rst_rsp0_v", rsp0_valid, 0);
    chk("rst_rsp1_rd", rsp1_rdata, 0);

    // release: req0 wins from IDLE, issues a read (T)
    tick();
    reset_n = 1'b1;
    @(negedge clk);
    chk("t1_ready0", req0_ready, 1);
    chk("t1_ready1", req1_ready, 0);
    chk("t1_ram_rd", ram_read, 1);
    tick();
    // T+1: reset mid-flight with commands held
    reset_n = 1'b0;
    #1;
    chk("t1_async_rdy0", req0_ready, 0);
    chk("t1_async_en", ram_enable, 0);
    chk("t1_async_rdp", ram_read, 0);
    set0(1'b1, 1'b1, 6'h30, 8'hC0);
    set1(1'b1, 1'b1, 6'h31, 8'hC1);
    tick();
    tick();
    reset_n = 1'b1;
    @(negedge clk);
    chk("t1_rearb_rdy0", req0_ready, 1);
    chk("t1_rearb_rdy1", req1_ready, 0);
    chk("t1_rsp0_post", rsp0_valid, 0);
    tick();
    set0(1'b0, 1'b0, 6'h00, 8'h00);
    set1(1'b0, 1'b0, 6'h00, 8'h00);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t1_no_rsp0", rsp0_valid, 0);
      chk("t1_no_rsp1", rsp1_valid, 0);
      tick();
    end

    // single owner: write then read 0x05
    set0(1'b1, 1'b1, 6'h05, 8'hA5);
    @(negedge clk);
    chk("t2_wr_rdy", req0_ready, 1);
    chk("t2_wr_rd", ram_read, 0);
    chk("t2_wr_addr", ram_address, 6'h05);
    chk("t2_wr_data", ram_data_in, 8'hA5);
    tick();
    set0(1'b1, 1'b0, 6'h05, 8'h00);
    @(negedge clk);
    chk("t2_rd_rdy", req0_ready, 1);
    chk("t2_rd_rd", ram_read, 1);
    tick();
    set0(1'b0, 1'b0, 6'h00, 8'h00);
    @(negedge clk);
    chk("t2_rsp_t1", rsp0_valid, 0);
    tick();
    @(negedge clk);
    chk("t2_rsp_v", rsp0_valid, 1);
    chk("t2_rsp_d", rsp0_rdata, 8'hA5);
    chk("t2_rsp1_v", rsp1_valid, 0);
    tick();
    @(negedge clk);
    chk("t2_rsp_end", rsp0_valid, 0);
    tick();

    // back-to-back: preload 1..3 via req1, then read
    set1(1'b1, 1'b1, 6'h01, 8'h11);
    @(negedge clk);
    chk("t4_wr_rdy1", req1_ready, 1);
    tick();
    set1(1'b1, 1'b1, 6'h02, 8'h22);
    tick();
    set1(1'b1, 1'b1, 6'h03, 8'h33);
    tick();
    set1(1'b1, 1'b0, 6'h01, 8'h00);
    tick();
    set1(1'b1, 1'b0, 6'h02, 8'h00);
    @(negedge clk);
    chk("t4_no_rsp", rsp1_valid, 0);
    tick();
    set1(1'b1, 1'b0, 6'h03, 8'h00);
    @(negedge clk);
    chk("t4_v1", rsp1_valid, 1);
    chk("t4_d1", rsp1_rdata, 8'h11);
    tick();
    set1(1'b0, 1'b0, 6'h00, 8'h00);
    @(negedge clk);
    chk("t4_v2", rsp1_valid, 1);
    chk("t4_d2", rsp1_rdata, 8'h22);
    tick();
    @(negedge clk);
    chk("t4_v3", rsp1_valid, 1);
    chk("t4_d3", rsp1_rdata, 8'h33);
    chk("t4_rsp0", rsp0_valid, 0);
    tick();
    @(negedge clk);
    chk("t4_end", rsp1_valid, 0);
    tick();

    // contention with bursts of 4
    set0(1'b1, 1'b0, 6'h01, 8'h00);
    set1(1'b1, 1'b0, 6'h02, 8'h00);
    for (int k = 0; k < 11; k++) begin
      if (k == 9) begin
        req0_valid = 1'b0;
        req1_valid = 1'b0;
      end
      @(negedge clk);
      if (k < 9) begin
        chk("t3_rdy0", req0_ready, gexp[k] == 0);
        chk("t3_rdy1", req1_ready, gexp[k] == 1);
      end
      if (k < 2) begin
        chk("t3_rsp0_pre", rsp0_valid, 0);
      end else begin
        chk("t3_rsp0_v", rsp0_valid, gexp[k-2] == 0);
        chk("t3_rsp1_v", rsp1_valid, gexp[k-2] == 1);
        if (gexp[k-2] == 0)
          chk("t3_rsp0_d", rsp0_rdata, 8'h11);
        else
          chk("t3_rsp1_d", rsp1_rdata, 8'h22);
      end
      tick();
    end

    // early release after two req0 beats
    set0(1'b1, 1'b1, 6'h10, 8'h01);
    @(negedge clk);
    chk("t5_a_rdy0", req0_ready, 1);
    tick();
    set0(1'b1, 1'b1, 6'h11, 8'h02);
    set1(1'b1, 1'b1, 6'h20, 8'h03);
    @(negedge clk);
    chk("t5_b_rdy0", req0_ready, 1);
    chk("t5_b_rdy1", req1_ready, 0);
    tick();
    req0_valid = 1'b0;
    @(negedge clk);
    chk("t5_c_rdy1", req1_ready, 1);
    chk("t5_c_en", ram_enable, 1);
    tick();
    req0_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t5_burst_rdy1", req1_ready, 1);
      chk("t5_burst_rdy0", req0_ready, 0);
      tick();
    end
    @(negedge clk);
    chk("t5_swap_rdy0", req0_ready, 1);
    chk("t5_swap_rdy1", req1_ready, 0);
    tick();
    set0(1'b0, 1'b0, 6'h00, 8'h00);
    set1(1'b0, 1'b0, 6'h00, 8'h00);
    tick();

    // read-after-write across ports
    set1(1'b1, 1'b1, 6'h3F, 8'h5A);
    @(negedge clk);
    chk("t6_wr_rdy1", req1_ready, 1);
    tick();
    set1(1'b0, 1'b0, 6'h00, 8'h00);
    set0(1'b1, 1'b0, 6'h3F, 8'h00);
    @(negedge clk);
    chk("t6_rd_rdy0", req0_ready, 1);
    chk("t6_rd_addr", ram_address, 6'h3F);
    tick();
    set0(1'b0, 1'b0, 6'h00, 8'h00);
    @(negedge clk);
    chk("t6_t2_v", rsp0_valid, 0);
    tick();
    @(negedge clk);
    chk("t6_t3_v", rsp0_valid, 1);
    chk("t6_t3_d", rsp0_rdata, 8'h5A);
    chk("t6_t3_v1", rsp1_valid, 0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
